parity_stream_receiver: RTL and testbench

//   Receive end of the 16-bit valid/parity sample stream driven by the filter datapath.

---
 rtl/parity_stream_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 47 ++++
 rtl/parity_stream_receiver.sv | 138 +++++++++++++
 tb/tb_parity_stream_receiver.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/parity_stream_pkg.sv
// Shared types, default widths and the parity helper for the parity stream receiver.
package parity_stream_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_FIFO_DEPTH = 4;
  localparam int DEFAULT_LOCK_GOOD  = 2;
  localparam int DEFAULT_UNLOCK_BAD = 2;
  localparam int DEFAULT_CNT_WIDTH  = 8;

  // Callers zero-extend their sample into this width before calling even_parity.
  localparam int MAX_DATA_WIDTH = 64;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } rx_state_t;

  function automatic logic even_parity(input logic [MAX_DATA_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with extra-MSB pointers; a pop frees room for a push in the same cycle.
module sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; the empty flag hides stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/parity_stream_receiver.sv
// Parity-checking stream receiver: lock FSM, good-sample buffering and saturating statistics.
module parity_stream_receiver
  import parity_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int LOCK_GOOD  = DEFAULT_LOCK_GOOD,
  parameter int UNLOCK_BAD = DEFAULT_UNLOCK_BAD,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_parity,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  locked,
  output logic                  err_sticky,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [CNT_WIDTH-1:0]  drop_count,
  input  logic                  clear_stats
);

  localparam int RUN_MAX = (LOCK_GOOD > UNLOCK_BAD) ? LOCK_GOOD : UNLOCK_BAD;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam logic [RUN_W-1:0] LOCK_GOOD_V  = RUN_W'(LOCK_GOOD);
  localparam logic [RUN_W-1:0] UNLOCK_BAD_V = RUN_W'(UNLOCK_BAD);

  rx_state_t             state;
  rx_state_t             state_nxt;
  logic [RUN_W-1:0]      good_run;
  logic [RUN_W-1:0]      good_run_nxt;
  logic [RUN_W-1:0]      bad_run;
  logic [RUN_W-1:0]      bad_run_nxt;

  logic                  beat_bad;
  logic                  beat_good;
  logic                  push_req;
  logic                  pop;
  logic                  drop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;

  assign beat_bad  = in_valid & (even_parity(MAX_DATA_WIDTH'(in_data)) ^ in_parity);
  assign beat_good = in_valid & ~beat_bad;
  assign push_req  = (state == LOCKED) & beat_good;
  assign pop       = out_valid & out_ready;
  assign drop      = push_req & fifo_full & ~pop;

  assign locked    = (state == LOCKED);
  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_head;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (in_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= HUNT;
      good_run <= '0;
      bad_run  <= '0;
    end else begin
      state    <= state_nxt;
      good_run <= good_run_nxt;
      bad_run  <= bad_run_nxt;
    end
  end

  // Idle cycles leave the runs intact; only valid beats move the counters.
  always_comb begin
    state_nxt    = state;
    good_run_nxt = good_run;
    bad_run_nxt  = bad_run;
    case (state)
      HUNT: begin
        if (beat_good) begin
          if (good_run + 1'b1 == LOCK_GOOD_V) begin
            state_nxt    = LOCKED;
            good_run_nxt = '0;
            bad_run_nxt  = '0;
          end else begin
            good_run_nxt = good_run + 1'b1;
          end
        end else if (beat_bad) begin
          good_run_nxt = '0;
        end
      end
      LOCKED: begin
        if (beat_good) begin
          bad_run_nxt = '0;
        end else if (beat_bad) begin
          if (bad_run + 1'b1 == UNLOCK_BAD_V) begin
            state_nxt    = HUNT;
            good_run_nxt = '0;
            bad_run_nxt  = '0;
          end else begin
            bad_run_nxt = bad_run + 1'b1;
          end
        end
      end
      default: begin
        state_nxt    = HUNT;
        good_run_nxt = '0;
        bad_run_nxt  = '0;
      end
    endcase
  end

  // clear_stats wins over any error or drop landing in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || clear_stats) begin
      err_count  <= '0;
      drop_count <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (beat_bad) begin
        err_sticky <= 1'b1;
        if (err_count != '1) err_count <= err_count + 1'b1;
      end
      if (drop && (drop_count != '1)) drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_parity_stream_receiver.sv
// Directed bench for parity_stream_receiver with a queue-based reference model checked every cycle.
module tb_parity_stream_receiver;

  localparam int DEPTH      = 4;
  localparam int LOCK_GOOD  = 2;
  localparam int UNLOCK_BAD = 2;
  localparam int CNT_MAX    = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_parity;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        locked;
  logic        err_sticky;
  logic [7:0]  err_count;
  logic [7:0]  drop_count;
  logic        clear_stats;

  int tests_run    = 0;
  int tests_failed = 0;

  parity_stream_receiver dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_parity   (in_parity),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .locked      (locked),
    .err_sticky  (err_sticky),
    .err_count   (err_count),
    .drop_count  (drop_count),
    .clear_stats (clear_stats)
  );

  always #5 clk = ~clk;

  // Reference model: plain queue plus integer run counts and statistics.
  logic [15:0] m_q[$];
  bit          m_locked;
  bit          m_sticky;
  int          m_good;
  int          m_bad;
  int          m_err;
  int          m_drop;
  bit          model_live = 0;

  always @(posedge clk) begin
    bit is_bad, is_good, dropped;
    if (reset) begin
      m_q.delete();
      m_locked = 0; m_sticky = 0;
      m_good = 0; m_bad = 0; m_err = 0; m_drop = 0;
      model_live = 1;
    end else begin
      is_bad  = in_valid && (($countones(in_data) % 2 == 1) != in_parity);
      is_good = in_valid && !is_bad;
      dropped = 0;
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      if (m_locked && is_good) begin
        if (m_q.size() < DEPTH) m_q.push_back(in_data);
        else dropped = 1;
      end
      if (clear_stats) begin
        m_err = 0; m_drop = 0; m_sticky = 0;
      end else begin
        if (is_bad) begin
          m_sticky = 1;
          if (m_err < CNT_MAX) m_err++;
        end
        if (dropped && m_drop < CNT_MAX) m_drop++;
      end
      if (!m_locked) begin
        if (is_good) begin
          m_good++;
          if (m_good == LOCK_GOOD) begin m_locked = 1; m_good = 0; m_bad = 0; end
        end else if (is_bad) m_good = 0;
      end else begin
        if (is_good) m_bad = 0;
        else if (is_bad) begin
          m_bad++;
          if (m_bad == UNLOCK_BAD) begin m_locked = 0; m_bad = 0; m_good = 0; end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_live) begin
      checkOutput("cyc_locked", 32'(locked), 32'(m_locked));
      checkOutput("cyc_out_valid", 32'(out_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) checkOutput("cyc_out_data", 32'(out_data), 32'(m_q[0]));
      checkOutput("cyc_err_count", 32'(err_count), 32'(m_err));
      checkOutput("cyc_drop_count", 32'(drop_count), 32'(m_drop));
      checkOutput("cyc_err_sticky", 32'(err_sticky), 32'(m_sticky));
    end
  end

  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic p,
                               input logic r, input logic c);
    in_valid    = v;
    in_data     = d;
    in_parity   = p;
    out_ready   = r;
    clear_stats = c;
    @(negedge clk);
  endtask

  logic [15:0] fill_words [4];
  logic        fill_par   [4];
  logic [15:0] drain_a    [4];
  logic [15:0] drain_b    [4];

  initial begin
    fill_words = '{16'h0003, 16'h0004, 16'h0005, 16'h0006};
    fill_par   = '{1'b0, 1'b1, 1'b0, 1'b0};
    drain_a    = '{16'h0003, 16'h0004, 16'h0005, 16'h0006};
    drain_b    = '{16'h0004, 16'h0005, 16'h0006, 16'h0009};

    reset = 1'b1; in_valid = 0; in_data = '0; in_parity = 0; out_ready = 0; clear_stats = 0;
    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_data", 32'(out_data), 32'd0);
    checkOutput("reset_locked", 32'(locked), 32'd0);
    checkOutput("reset_err_count", 32'(err_count), 32'd0);
    reset = 1'b0;

    // Lock on two 0x000C beats, third is stored.
    applyStimulus(1, 16'h000C, 0, 0, 0);
    checkOutput("hunt_beat1_locked", 32'(locked), 32'd0);
    applyStimulus(1, 16'h000C, 0, 0, 0);
    checkOutput("hunt_beat2_locked", 32'(locked), 32'd1);
    checkOutput("hunt_beat2_discarded", 32'(out_valid), 32'd0);
    applyStimulus(1, 16'h000C, 0, 0, 0);
    checkOutput("beat3_out_valid", 32'(out_valid), 32'd1);
    checkOutput("beat3_out_data", 32'(out_data), 32'h000C);
    checkOutput("beat3_err_count", 32'(err_count), 32'd0);
    applyStimulus(0, 16'h0000, 0, 1, 0);
    checkOutput("pop_empty", 32'(out_valid), 32'd0);

    // Two bad beats unlock.
    applyStimulus(1, 16'h0001, 0, 0, 0);
    applyStimulus(1, 16'h0001, 0, 0, 0);
    checkOutput("unlock_err_count", 32'(err_count), 32'd2);
    checkOutput("unlock_sticky", 32'(err_sticky), 32'd1);
    checkOutput("unlock_locked", 32'(locked), 32'd0);
    checkOutput("unlock_no_push", 32'(out_valid), 32'd0);

    // Relock, then overfill with out_ready low.
    applyStimulus(1, 16'h000C, 0, 0, 0);
    applyStimulus(0, 16'h0000, 0, 0, 0);
    applyStimulus(1, 16'h000C, 0, 0, 0);
    checkOutput("relock_across_gap", 32'(locked), 32'd1);
    for (int i = 0; i < 4; i++) applyStimulus(1, fill_words[i], fill_par[i], 0, 0);
    applyStimulus(1, 16'h0007, 1, 0, 0);
    applyStimulus(1, 16'h0008, 1, 0, 0);
    checkOutput("overfill_drop_count", 32'(drop_count), 32'd2);
    checkOutput("overfill_head", 32'(out_data), 32'h0003);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_a_data", 32'(out_data), 32'(drain_a[i]));
      applyStimulus(0, 16'h0000, 0, 1, 0);
    end
    checkOutput("drain_a_empty", 32'(out_valid), 32'd0);

    // Refill, then push into a full FIFO while popping.
    for (int i = 0; i < 4; i++) applyStimulus(1, fill_words[i], fill_par[i], 0, 0);
    applyStimulus(1, 16'h0009, 0, 1, 0);
    checkOutput("full_pushpop_drop", 32'(drop_count), 32'd2);
    checkOutput("full_pushpop_head", 32'(out_data), 32'h0004);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_b_data", 32'(out_data), 32'(drain_b[i]));
      applyStimulus(0, 16'h0000, 0, 1, 0);
    end
    checkOutput("drain_b_empty", 32'(out_valid), 32'd0);

    // Bad beat coincident with clear_stats.
    applyStimulus(1, 16'h0001, 0, 0, 1);
    checkOutput("clear_err_count", 32'(err_count), 32'd0);
    checkOutput("clear_sticky", 32'(err_sticky), 32'd0);
    checkOutput("clear_drop_count", 32'(drop_count), 32'd0);
    checkOutput("clear_keeps_lock", 32'(locked), 32'd1);

    // Buffer three words, then reset mid-operation.
    applyStimulus(1, 16'h000A, 0, 0, 0);
    applyStimulus(1, 16'h0001, 0, 0, 0);
    applyStimulus(1, 16'h000B, 1, 0, 0);
    applyStimulus(1, 16'h000C, 0, 0, 0);
    checkOutput("pre_reset_err", 32'(err_count), 32'd1);
    checkOutput("pre_reset_head", 32'(out_data), 32'h000A);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mid_reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_reset_locked", 32'(locked), 32'd0);
    checkOutput("mid_reset_err", 32'(err_count), 32'd0);
    checkOutput("mid_reset_drop", 32'(drop_count), 32'd0);
    applyStimulus(1, 16'h000C, 0, 0, 0);
    checkOutput("relock_beat1", 32'(locked), 32'd0);
    applyStimulus(1, 16'h000C, 0, 0, 0);
    checkOutput("relock_beat2", 32'(locked), 32'd1);

    // Error counter saturates at all-ones.
    for (int i = 0; i < 260; i++) applyStimulus(1, 16'h0001, 0, 0, 0);
    checkOutput("err_saturate", 32'(err_count), 32'd255);
    checkOutput("err_saturate_sticky", 32'(err_sticky), 32'd1);
    applyStimulus(0, 16'h0000, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
